deck_pool: RTL and testbench
============================

# deck_pool

Parametrised successor to the UNO deck block: a two-bank card store with a draw pile and a discard pile. It loads cards serially, shuffles them with an LFSR-driven Fisher-Yates pass, and serves multi-card draw requests one card per cycle. When the draw pile runs out mid-request, it refills itself from the discard pile, keeping the face-up card. It sits between the game-control FSM and the per-player hand stores.

## Interface
Parameters:
- CARD_W, 6, card encoding width ({colour[1:0], value[3:0]} at default)
- DECK_SIZE, 108, capacity of each bank; IDX_W = $clog2(DECK_SIZE), CNT_W = $clog2(DECK_SIZE+1)
- MAX_DRAW, 4, largest single request; NUM_W = $clog2(MAX_DRAW+1)
- LFSR_W, 16, shuffle LFSR width (Galois, taps 0xB400 at default)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_load_valid / i_load_card  in  1 / CARD_W  push card onto draw pile
- i_start  in  1  shuffle draw pile
- i_draw_valid / i_draw_num  in  1 / NUM_W  draw request, 1..MAX_DRAW cards
- o_ready  out  1  IDLE; load/start/draw accepted only when high
- o_card_valid / o_card  out  1 / CARD_W  one drawn card per valid cycle
- o_draw_done  out  1  pulse: request finished
- o_draw_short  out  1  pulse with o_draw_done: fewer cards delivered than requested
- i_discard_valid / i_discard_card  in  1 / CARD_W  push onto discard pile
- o_discard_ready  out  1  low only in REFILL
- o_top_discard  out  CARD_W  face-up card (0 when discard empty)
- o_draw_cnt / o_disc_cnt  out  CNT_W / CNT_W  pile occupancies

## Operation
- Two banks, mem0/mem1, DECK_SIZE×CARD_W each. Register sel selects the draw bank; the other bank is discard. Pile tops are at index cnt-1.
- States: IDLE, SHUFFLE, DRAW, REFILL.
- IDLE: i_load_valid writes draw[draw_cnt], draw_cnt+1; ignored when draw_cnt==DECK_SIZE. Priority when several are asserted: i_draw_valid > i_start > i_load_valid.
- i_start: LFSR ← LFSR ^ free-running counter (forced to 1 if zero), idx ← draw_cnt-1, → SHUFFLE. With draw_cnt ≤ 1, returns to IDLE next cycle.
- SHUFFLE: r = LFSR[IDX_W-1:0] & mask(idx), where mask = all-ones up to the MSB of idx. r > idx: reject and retry. Otherwise swap draw[idx] and draw[r], then idx-1. Leaves when idx==0, returning to the saved return state (IDLE or DRAW).
- The LFSR advances every cycle in every state.
- DRAW: remaining ← i_draw_num (0 treated as 1). Each cycle with draw_cnt>0: o_card = draw[draw_cnt-1], o_card_valid=1, draw_cnt-1, remaining-1. When remaining reaches 0: o_draw_done, → IDLE.
- DRAW with draw_cnt==0: see Configuration.
- REFILL (1 cycle): sel flips, draw_cnt ← disc_cnt-1, new discard[0] ← old top discard, disc_cnt ← 1. Then → SHUFFLE with return to DRAW.
- Discards: accepted in IDLE/SHUFFLE/DRAW. Write discard[disc_cnt], disc_cnt+1; dropped when disc_cnt==DECK_SIZE.

## Timing
- Reset: state IDLE, sel=0, counts 0, LFSR=1, counter 0, all outputs 0 except o_ready=1 and o_discard_ready=1. Bank contents are not cleared; counts define validity. Reset mid-shuffle or mid-draw aborts with no done pulse.
- Request accepted at edge T → first o_card_valid in cycle T+1, then back-to-back cards. o_ready low from T+1 until the cycle after o_draw_done.
- Refill adds 1 cycle plus the shuffle cycles; expected ≤ 2 cycles per card.
- o_card, o_top_discard and the counts are registered-state driven: the updated value is visible the cycle after the event.

## Configuration
- DECK_AUTO_REFILL_EN defined: DRAW with draw_cnt==0 and disc_cnt ≥ 2 → REFILL; disc_cnt ≤ 1 → o_draw_done + o_draw_short, → IDLE.
- DECK_AUTO_REFILL_EN undefined: REFILL is absent. DRAW with draw_cnt==0 always ends with o_draw_done + o_draw_short; o_discard_ready is tied high.

## Test plan
- Load 108 cards 0..107 mod 64, draw 4 → o_card = card107,106,105,104 on consecutive cycles; o_draw_done on the 4th; o_draw_cnt = 104.
- Load 108, i_start → SHUFFLE completes; draw all 108 → output multiset equals input multiset; the order differs from load order for 2 distinct counter seeds.
- Load 2, discard 0x05,0x11,0x2A, draw 4 (EN) → 2 cards, REFILL, 2 cards from {0x05,0x11}; o_top_discard=0x2A; o_disc_cnt=1; no short.
- Same stimulus without EN → 2 cards; o_draw_done+o_draw_short; counts 0/3.
- Draw 2 with draw_cnt=0, disc_cnt=1 (EN) → no cards; done+short in T+1.
- 109th load → ignored, o_draw_cnt stays 108. Reset asserted mid-shuffle → next cycle IDLE, counts 0, o_ready=1.

Source files
------------

// File: rtl/deck_pool_if.sv
// deck_pool_if: handshake and status bundle between the game controller
// (master) and the deck_pool card store (slave).
//   i_load_valid/i_load_card      push a card onto the draw pile
//   i_start                       shuffle the draw pile
//   i_draw_valid/i_draw_num       draw 1..MAX_DRAW cards
//   i_discard_valid/i_discard_card push a card onto the discard pile
//   o_ready, o_card_valid/o_card, o_draw_done, o_draw_short,
//   o_discard_ready, o_top_discard, o_draw_cnt, o_disc_cnt  status/results
interface deck_pool_if #(
   parameter int CARD_W    = 6,
   parameter int DECK_SIZE = 108,
   parameter int MAX_DRAW  = 4
);
   localparam int CNT_W = $clog2(DECK_SIZE + 1);
   localparam int NUM_W = $clog2(MAX_DRAW + 1);

   logic              i_load_valid;
   logic [CARD_W-1:0] i_load_card;
   logic              i_start;
   logic              i_draw_valid;
   logic [NUM_W-1:0]  i_draw_num;
   logic              i_discard_valid;
   logic [CARD_W-1:0] i_discard_card;
   logic              o_ready;
   logic              o_card_valid;
   logic [CARD_W-1:0] o_card;
   logic              o_draw_done;
   logic              o_draw_short;
   logic              o_discard_ready;
   logic [CARD_W-1:0] o_top_discard;
   logic [CNT_W-1:0]  o_draw_cnt;
   logic [CNT_W-1:0]  o_disc_cnt;

   modport master (
      output i_load_valid, i_load_card, i_start, i_draw_valid, i_draw_num,
             i_discard_valid, i_discard_card,
      input  o_ready, o_card_valid, o_card, o_draw_done, o_draw_short,
             o_discard_ready, o_top_discard, o_draw_cnt, o_disc_cnt
   );

   modport slave (
      input  i_load_valid, i_load_card, i_start, i_draw_valid, i_draw_num,
             i_discard_valid, i_discard_card,
      output o_ready, o_card_valid, o_card, o_draw_done, o_draw_short,
             o_discard_ready, o_top_discard, o_draw_cnt, o_disc_cnt
   );
endinterface

// File: rtl/deck_pool.sv
// deck_pool: two-bank card store with a draw pile and a discard pile.
// Cards are loaded serially, shuffled in place with an LFSR-driven
// Fisher-Yates pass, and served one card per cycle for multi-card draws.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   bus      deck_pool_if slave modport (load/start/draw/discard in,
//            card stream, done/short pulses, pile status out)
// Optional feature macro: DECK_AUTO_REFILL_EN. When defined, a draw that
// empties the draw pile refills it from the discard pile (keeping the
// face-up card) and reshuffles before continuing. When undefined, such a
// draw ends short and the REFILL state is never entered.
//
// state   | meaning
// IDLE    | accepts load / start / draw
// SHUFFLE | one Fisher-Yates step per cycle, then back to ret_state
// DRAW    | one card per cycle until the request is satisfied
// REFILL  | swap banks, keep top discard, then shuffle and resume DRAW
module deck_pool #(
   parameter int                CARD_W    = 6,
   parameter int                DECK_SIZE = 108,
   parameter int                MAX_DRAW  = 4,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
   input logic        i_clk,
   input logic        i_rst_n,
   deck_pool_if.slave bus
);
   localparam int IDX_W = $clog2(DECK_SIZE);
   localparam int CNT_W = $clog2(DECK_SIZE + 1);
   localparam int NUM_W = $clog2(MAX_DRAW + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHUFFLE, ST_DRAW, ST_REFILL} state_t;

   state_t            state;
   state_t            ret_state;
   logic              sel;
   logic [CNT_W-1:0]  draw_cnt;
   logic [CNT_W-1:0]  disc_cnt;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] ctr;
   logic [IDX_W-1:0]  idx;
   logic [NUM_W-1:0]  remaining;
   logic [CARD_W-1:0] mem0 [DECK_SIZE];
   logic [CARD_W-1:0] mem1 [DECK_SIZE];

   logic [IDX_W-1:0]  draw_top;
   logic [IDX_W-1:0]  disc_top;
   logic [IDX_W-1:0]  idx_mask;
   logic [IDX_W-1:0]  swap_r;
   logic [CARD_W-1:0] draw_card;
   logic [CARD_W-1:0] disc_card;
   logic [CARD_W-1:0] card_idx;
   logic [CARD_W-1:0] card_r;
   logic [LFSR_W-1:0] lfsr_next;
   logic [LFSR_W-1:0] seed;
   logic              draw_has;
   logic              disc_has;
   logic              card_out;
   logic              refill_go;
   logic              short_out;
   logic              done_out;
   logic              disc_accept;

   // sel picks the draw bank; the other bank always holds the discard pile.
   always_comb begin
      draw_top  = IDX_W'(draw_cnt - CNT_W'(1));
      disc_top  = IDX_W'(disc_cnt - CNT_W'(1));
      draw_card = sel ? mem1[draw_top] : mem0[draw_top];
      disc_card = sel ? mem0[disc_top] : mem1[disc_top];
      // Smallest all-ones mask covering idx keeps the rejection rate below 1/2.
      idx_mask = idx;
      for (int i = 1; i < IDX_W; i++) begin
         idx_mask = idx_mask | (idx_mask >> 1);
      end
      swap_r   = lfsr[IDX_W-1:0] & idx_mask;
      card_idx = sel ? mem1[idx] : mem0[idx];
      card_r   = sel ? mem1[swap_r] : mem0[swap_r];
      lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      seed      = ((lfsr ^ ctr) == '0) ? LFSR_W'(1) : (lfsr ^ ctr);
   end

   assign draw_has = (draw_cnt != '0);
   assign disc_has = (disc_cnt != '0);
   assign card_out = (state == ST_DRAW) && draw_has;
`ifdef DECK_AUTO_REFILL_EN
   assign refill_go = (state == ST_DRAW) && !draw_has && (disc_cnt >= CNT_W'(2));
`else
   assign refill_go = 1'b0;
`endif
   assign short_out   = (state == ST_DRAW) && !draw_has && !refill_go;
   assign done_out    = (card_out && (remaining == NUM_W'(1))) || short_out;
   assign disc_accept = bus.i_discard_valid && (state != ST_REFILL) &&
                        (disc_cnt != CNT_W'(DECK_SIZE));

   // Outputs are pure decodes of registered state, so a card accepted at
   // edge T is presented throughout cycle T+1.
   assign bus.o_ready       = (state == ST_IDLE);
   assign bus.o_card_valid  = card_out;
   assign bus.o_card        = card_out ? draw_card : '0;
   assign bus.o_draw_done   = done_out;
   assign bus.o_draw_short  = short_out;
`ifdef DECK_AUTO_REFILL_EN
   assign bus.o_discard_ready = (state != ST_REFILL);
`else
   assign bus.o_discard_ready = 1'b1;
`endif
   assign bus.o_top_discard = disc_has ? disc_card : '0;
   assign bus.o_draw_cnt    = draw_cnt;
   assign bus.o_disc_cnt    = disc_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         ret_state <= ST_IDLE;
         sel       <= 1'b0;
         draw_cnt  <= '0;
         disc_cnt  <= '0;
         lfsr      <= LFSR_W'(1);
         ctr       <= '0;
         idx       <= '0;
         remaining <= '0;
      end else begin
         lfsr <= lfsr_next;
         ctr  <= ctr + LFSR_W'(1);

         if (disc_accept) begin
            if (sel) mem0[IDX_W'(disc_cnt)] <= bus.i_discard_card;
            else     mem1[IDX_W'(disc_cnt)] <= bus.i_discard_card;
            disc_cnt <= disc_cnt + CNT_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (bus.i_draw_valid) begin
                  remaining <= (bus.i_draw_num == '0) ? NUM_W'(1) : bus.i_draw_num;
                  state     <= ST_DRAW;
               end else if (bus.i_start) begin
                  lfsr      <= seed;
                  idx       <= (draw_cnt > CNT_W'(1)) ? draw_top : '0;
                  ret_state <= ST_IDLE;
                  state     <= ST_SHUFFLE;
               end else if (bus.i_load_valid && (draw_cnt != CNT_W'(DECK_SIZE))) begin
                  if (sel) mem1[IDX_W'(draw_cnt)] <= bus.i_load_card;
                  else     mem0[IDX_W'(draw_cnt)] <= bus.i_load_card;
                  draw_cnt <= draw_cnt + CNT_W'(1);
               end
            end

            ST_SHUFFLE: begin
               if (idx == '0) begin
                  state <= ret_state;
               end else if (swap_r <= idx) begin
                  if (sel) begin
                     mem1[idx]    <= card_r;
                     mem1[swap_r] <= card_idx;
                  end else begin
                     mem0[idx]    <= card_r;
                     mem0[swap_r] <= card_idx;
                  end
                  idx <= idx - IDX_W'(1);
               end
            end

            ST_DRAW: begin
               if (draw_has) begin
                  draw_cnt  <= draw_cnt - CNT_W'(1);
                  remaining <= remaining - NUM_W'(1);
                  if (remaining == NUM_W'(1)) state <= ST_IDLE;
               end else if (refill_go) begin
                  state <= ST_REFILL;
               end else begin
                  state <= ST_IDLE;
               end
            end

`ifdef DECK_AUTO_REFILL_EN
            ST_REFILL: begin
               // Old draw bank becomes the discard bank, seeded with the
               // face-up card; the rest of the old discard pile is redealt.
               sel      <= ~sel;
               draw_cnt <= disc_cnt - CNT_W'(1);
               if (sel) mem1[0] <= disc_card;
               else     mem0[0] <= disc_card;
               disc_cnt  <= CNT_W'(1);
               idx       <= IDX_W'(disc_cnt - CNT_W'(2));
               ret_state <= ST_DRAW;
               state     <= ST_SHUFFLE;
            end
`endif

            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_deck_pool.sv
module tb_deck_pool;
   logic clk;
   logic rst_n;

   deck_pool_if #(.CARD_W(6), .DECK_SIZE(108), .MAX_DRAW(4)) bus ();

   deck_pool #(.CARD_W(6), .DECK_SIZE(108), .MAX_DRAW(4), .LFSR_W(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit short_f;
      int ncards;
   } done_t;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [5:0] exp_q[$];
   logic [5:0] cap_q[$];
   done_t      done_q[$];
   bit         capture = 1'b0;
   int         since = 0;
   logic [5:0] e_card;
   done_t      e_done;
   logic [5:0] ord0 [108];
   logic [5:0] ord1 [108];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a card or done.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_card_valid) begin
            since++;
            if (capture) begin
               cap_q.push_back(bus.o_card);
            end else if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL card_extra: got %0h expected none", bus.o_card);
            end else begin
               e_card = exp_q.pop_front();
               chk("card", bus.o_card, e_card);
            end
         end
         if (bus.o_draw_done) begin
            if (done_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done_extra: got done expected none");
            end else begin
               e_done = done_q.pop_front();
               chk("done_short", bus.o_draw_short, e_done.short_f);
               chk("done_ncards", since, e_done.ncards);
            end
            since = 0;
         end
      end else begin
         since = 0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (bus.o_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got o_ready=0 expected 1 within 3000 cycles");
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_one(input logic [5:0] c);
      bus.i_load_valid = 1'b1;
      bus.i_load_card  = c;
      tick();
      bus.i_load_valid = 1'b0;
   endtask

   task automatic load_seq();
      for (int i = 0; i < 108; i++) load_one(6'(i % 64));
   endtask

   task automatic discard_one(input logic [5:0] c);
      bus.i_discard_valid = 1'b1;
      bus.i_discard_card  = c;
      tick();
      bus.i_discard_valid = 1'b0;
   endtask

   task automatic do_draw(input int n, input bit first_valid);
      bus.i_draw_valid = 1'b1;
      bus.i_draw_num   = 3'(n);
      tick();
      bus.i_draw_valid = 1'b0;
      chk("first_valid_T1", bus.o_card_valid, first_valid);
      wait_ready();
   endtask

   task automatic do_draw_short(input int n);
      bus.i_draw_valid = 1'b1;
      bus.i_draw_num   = 3'(n);
      tick();
      bus.i_draw_valid = 1'b0;
      chk("short_valid_T1", bus.o_card_valid, 0);
      chk("short_done_T1", bus.o_draw_done, 1);
      chk("short_flag_T1", bus.o_draw_short, 1);
      wait_ready();
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   // Load 0..107 mod 64, shuffle after dly idle cycles, draw all 108.
   task automatic shuffle_run(input int dly, input bit which);
      int hist [64];
      int bad;
      int diff;
      do_reset();
      load_seq();
      repeat (dly) tick();
      pulse_start();
      wait_ready();
      chk("shuffle_cnt", bus.o_draw_cnt, 108);
      cap_q.delete();
      capture = 1'b1;
      for (int r = 0; r < 27; r++) begin
         done_q.push_back('{short_f: 1'b0, ncards: 4});
         do_draw(4, 1'b1);
      end
      capture = 1'b0;
      chk("shuffle_ncap", cap_q.size(), 108);
      for (int v = 0; v < 64; v++) hist[v] = 0;
      diff = 0;
      for (int k = 0; k < cap_q.size() && k < 108; k++) begin
         hist[cap_q[k]]++;
         if (cap_q[k] != 6'((107 - k) % 64)) diff++;
         if (which) ord1[k] = cap_q[k];
         else       ord0[k] = cap_q[k];
      end
      bad = 0;
      for (int v = 0; v < 64; v++) if (hist[v] != ((v < 44) ? 2 : 1)) bad++;
      chk("shuffle_multiset_bad_bins", bad, 0);
      n_cmp++;
      if (diff == 0) begin
         n_err++;
         $display("FAIL shuffle_order: got load order expected permuted order");
      end
      chk("shuffle_empty_cnt", bus.o_draw_cnt, 0);
   endtask

   initial begin
      int odiff;
      rst_n               = 1'b0;
      bus.i_load_valid    = 1'b0;
      bus.i_load_card     = '0;
      bus.i_start         = 1'b0;
      bus.i_draw_valid    = 1'b0;
      bus.i_draw_num      = '0;
      bus.i_discard_valid = 1'b0;
      bus.i_discard_card  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_ready", bus.o_ready, 1);
      chk("rst_discard_ready", bus.o_discard_ready, 1);
      chk("rst_draw_cnt", bus.o_draw_cnt, 0);
      chk("rst_disc_cnt", bus.o_disc_cnt, 0);
      chk("rst_top_discard", bus.o_top_discard, 0);
      chk("rst_card_valid", bus.o_card_valid, 0);
      chk("rst_done", bus.o_draw_done, 0);

      // Full deck, overflow load, unshuffled draw of 4.
      load_seq();
      chk("full_cnt", bus.o_draw_cnt, 108);
      load_one(6'h3F);
      chk("overflow_cnt", bus.o_draw_cnt, 108);
      exp_q.push_back(6'h2B);
      exp_q.push_back(6'h2A);
      exp_q.push_back(6'h29);
      exp_q.push_back(6'h28);
      done_q.push_back('{short_f: 1'b0, ncards: 4});
      do_draw(4, 1'b1);
      chk("draw4_cnt", bus.o_draw_cnt, 104);

      // Reset in the middle of a shuffle.
      pulse_start();
      repeat (5) tick();
      chk("mid_shuffle_busy", bus.o_ready, 0);
      do_reset();
      chk("mid_rst_ready", bus.o_ready, 1);
      chk("mid_rst_draw_cnt", bus.o_draw_cnt, 0);
      chk("mid_rst_disc_cnt", bus.o_disc_cnt, 0);

      // Two shuffles with different counter seeds.
      shuffle_run(3, 1'b0);
      shuffle_run(20, 1'b1);
      odiff = 0;
      for (int k = 0; k < 108; k++) if (ord0[k] != ord1[k]) odiff++;
      n_cmp++;
      if (odiff == 0) begin
         n_err++;
         $display("FAIL seed_orders: got identical orders expected different");
      end

      // Draw past the end of the draw pile.
      do_reset();
      load_one(6'h3C);
      load_one(6'h3D);
      discard_one(6'h05);
      discard_one(6'h11);
      discard_one(6'h2A);
      chk("pre_top_discard", bus.o_top_discard, 6'h2A);
      chk("pre_disc_cnt", bus.o_disc_cnt, 3);
`ifdef DECK_AUTO_REFILL_EN
      cap_q.delete();
      capture = 1'b1;
      done_q.push_back('{short_f: 1'b0, ncards: 4});
      do_draw(4, 1'b1);
      capture = 1'b0;
      chk("refill_ncap", cap_q.size(), 4);
      if (cap_q.size() == 4) begin
         chk("refill_card0", cap_q[0], 6'h3D);
         chk("refill_card1", cap_q[1], 6'h3C);
         chk("refill_pair", ((cap_q[2] == 6'h05 && cap_q[3] == 6'h11) ||
                             (cap_q[2] == 6'h11 && cap_q[3] == 6'h05)) ? 1 : 0, 1);
      end
      chk("refill_top_discard", bus.o_top_discard, 6'h2A);
      chk("refill_disc_cnt", bus.o_disc_cnt, 1);
      chk("refill_draw_cnt", bus.o_draw_cnt, 0);
`else
      exp_q.push_back(6'h3D);
      exp_q.push_back(6'h3C);
      done_q.push_back('{short_f: 1'b1, ncards: 2});
      do_draw(4, 1'b1);
      chk("short_draw_cnt", bus.o_draw_cnt, 0);
      chk("short_disc_cnt", bus.o_disc_cnt, 3);
      chk("short_top_discard", bus.o_top_discard, 6'h2A);
`endif
      // Empty draw pile with nothing usable to refill from.
      done_q.push_back('{short_f: 1'b1, ncards: 0});
      do_draw_short(2);

      repeat (3) tick();
      chk("exp_q_drained", exp_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
